// File: rtl/pc_pkg.sv
// Shared op encoding for the fetch-stage program counter and its decode.
// Pure declarations, no logic; no latency.
// No flow control.
package pc_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NEXT   = 3'd0,
        OP_BRANCH = 3'd1,
        OP_JUMP   = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4
    } op_e;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO with occupancy counter.
// Push/pop take effect at the next edge; top is read from registered state.
// No backpressure: a push when full and a pop when empty are both ignored.
module ret_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [CNT_W-1:0] depth,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CNT_W-1:0] depth_q;
    logic [CNT_W-1:0] depth_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (depth_q == CNT_W'(DEPTH));
        empty   = (depth_q == '0);
        do_push = push && !full;
        do_pop  = pop && !empty && !push;

        depth_d = depth_q;
        if (do_push) begin
            depth_d = depth_q + CNT_W'(1);
        end else if (do_pop) begin
            depth_d = depth_q - CNT_W'(1);
        end

        // Loop-based select keeps the index width independent of DEPTH.
        mem_d = mem_q;
        top   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (do_push && (CNT_W'(i) == depth_q)) begin
                mem_d[i] = din;
            end
            if (CNT_W'(i) == (depth_q - CNT_W'(1))) begin
                top = mem_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // Contents are meaningless while depth is zero, so the array needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign depth = depth_q;

endmodule

// File: rtl/pc_stack_unit.sv
// Fetch-stage program counter with branch, jump and CALL/RET through a return stack.
// One-cycle latency: an op sampled at edge N is visible on all outputs after edge N.
// No backpressure: enable=0 holds state; overflow/underflow sets a sticky fault.
module pc_stack_unit
    import pc_pkg::*;
#(
    parameter int              ADDR_W      = 10,
    parameter int              DISP_W      = 8,
    parameter int              STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             enable,
    input  logic [OP_W-1:0]                  op,
    input  logic                             cond,
    input  logic [DISP_W-1:0]                disp,
    input  logic [ADDR_W-1:0]                target,
    output logic [ADDR_W-1:0]                address,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             stack_full,
    output logic                             stack_empty,
    output logic                             fault
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              fault_q;
    logic              fault_d;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] disp_sext;
    logic [ADDR_W-1:0] ret_addr;
    logic              stk_push;
    logic              stk_pop;
    logic              stk_full;
    logic              stk_empty;

    assign addr_inc  = addr_q + ADDR_W'(1);
    assign disp_sext = ADDR_W'($signed(disp));

    always_comb begin
        addr_d   = addr_q;
        fault_d  = fault_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;

        if (enable) begin
            case (op)
                OP_NEXT:   addr_d = addr_inc;
                OP_BRANCH: addr_d = cond ? (addr_q + disp_sext) : addr_inc;
                OP_JUMP:   addr_d = target;
                OP_CALL: begin
                    if (stk_full) begin
                        fault_d = 1'b1;
                    end else begin
                        stk_push = 1'b1;
                        addr_d   = target;
                    end
                end
                OP_RET: begin
                    if (stk_empty) begin
                        fault_d = 1'b1;
                    end else begin
                        stk_pop = 1'b1;
                        addr_d  = ret_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q  <= RESET_ADDR;
            fault_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            fault_q <= fault_d;
        end
    end

    ret_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (stk_push),
        .pop     (stk_pop),
        .din     (addr_inc),
        .top     (ret_addr),
        .depth   (depth),
        .full    (stk_full),
        .empty   (stk_empty)
    );

    assign address     = addr_q;
    assign fault       = fault_q;
    assign stack_full  = stk_full;
    assign stack_empty = stk_empty;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed scoreboard bench for pc_stack_unit (ADDR_W=10, DISP_W=8, STACK_DEPTH=4).
module tb_pc_stack_unit;
    import pc_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [2:0] op;
    logic       cond;
    logic [7:0] disp;
    logic [9:0] target;
    logic [9:0] address;
    logic [2:0] depth;
    logic       stack_full;
    logic       stack_empty;
    logic       fault;

    pc_stack_unit #(
        .ADDR_W      (10),
        .DISP_W      (8),
        .STACK_DEPTH (4),
        .RESET_ADDR  (10'd0)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .op          (op),
        .cond        (cond),
        .disp        (disp),
        .target      (target),
        .address     (address),
        .depth       (depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [9:0] addr;
        logic [2:0] dep;
        logic       flt;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Monitor: every negedge, compare entries whose result became visible at the last edge.
    initial begin
        exp_t e;
        logic exp_full;
        logic exp_empty;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e         = exp_q.pop_front();
                exp_full  = (e.dep == 3'd4);
                exp_empty = (e.dep == 3'd0);
                checks++;
                if (e.due != cyc || address !== e.addr || depth !== e.dep ||
                    stack_full !== exp_full || stack_empty !== exp_empty || fault !== e.flt) begin
                    failures++;
                    $display("FAIL %s: got addr=%0d depth=%0d full=%b empty=%b fault=%b, expected addr=%0d depth=%0d full=%b empty=%b fault=%b",
                             e.name, address, depth, stack_full, stack_empty, fault,
                             e.addr, e.dep, exp_full, exp_empty, e.flt);
                end
            end
        end
    end

    task automatic step(input string name, input logic rn, input logic en, input logic [2:0] o,
                        input logic c, input logic [7:0] d, input logic [9:0] t,
                        input logic [9:0] ea, input logic [2:0] ed, input logic ef);
        exp_t e;
        @(negedge clk);
        reset_n = rn;
        enable  = en;
        op      = o;
        cond    = c;
        disp    = d;
        target  = t;
        e.due   = cyc + 1;
        e.addr  = ea;
        e.dep   = ed;
        e.flt   = ef;
        e.name  = name;
        exp_q.push_back(e);
    endtask

    task automatic run(input string name, input logic [2:0] o, input logic c, input logic [7:0] d,
                       input logic [9:0] t, input logic [9:0] ea, input logic [2:0] ed, input logic ef);
        step(name, 1'b1, 1'b1, o, c, d, t, ea, ed, ef);
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        op      = OP_NEXT;
        cond    = 1'b0;
        disp    = 8'h00;
        target  = 10'd0;

        // Reset wins regardless of enable/op
        step("reset_next",  1'b0, 1'b1, OP_NEXT, 1'b0, 8'h00, 10'd0,  10'd0, 3'd0, 1'b0);
        step("reset_call",  1'b0, 1'b1, OP_CALL, 1'b0, 8'h00, 10'd55, 10'd0, 3'd0, 1'b0);

        // NEXT wrap and branches
        run("jump_1023",      OP_JUMP,   1'b0, 8'h00, 10'd1023, 10'd1023, 3'd0, 1'b0);
        run("next_wrap",      OP_NEXT,   1'b0, 8'h00, 10'd0,    10'd0,    3'd0, 1'b0);
        run("jump_100",       OP_JUMP,   1'b0, 8'h00, 10'd100,  10'd100,  3'd0, 1'b0);
        run("branch_m3",      OP_BRANCH, 1'b1, 8'hFD, 10'd0,    10'd97,   3'd0, 1'b0);
        run("jump_100b",      OP_JUMP,   1'b0, 8'h00, 10'd100,  10'd100,  3'd0, 1'b0);
        run("branch_nt",      OP_BRANCH, 1'b0, 8'hFD, 10'd0,    10'd101,  3'd0, 1'b0);
        run("jump_5",         OP_JUMP,   1'b0, 8'h00, 10'd5,    10'd5,    3'd0, 1'b0);
        run("branch_m8_wrap", OP_BRANCH, 1'b1, 8'hF8, 10'd0,    10'd1021, 3'd0, 1'b0);
        run("branch_p127",    OP_BRANCH, 1'b1, 8'h7F, 10'd0,    10'd124,  3'd0, 1'b0);

        // Nested calls and returns
        run("jump_10",  OP_JUMP, 1'b0, 8'h00, 10'd10,  10'd10,  3'd0, 1'b0);
        run("call_200", OP_CALL, 1'b0, 8'h00, 10'd200, 10'd200, 3'd1, 1'b0);
        run("call_300", OP_CALL, 1'b0, 8'h00, 10'd300, 10'd300, 3'd2, 1'b0);
        run("call_400", OP_CALL, 1'b0, 8'h00, 10'd400, 10'd400, 3'd3, 1'b0);
        run("call_500", OP_CALL, 1'b0, 8'h00, 10'd500, 10'd500, 3'd4, 1'b0);
        run("ret_401",  OP_RET,  1'b0, 8'h00, 10'd0,   10'd401, 3'd3, 1'b0);
        run("ret_301",  OP_RET,  1'b0, 8'h00, 10'd0,   10'd301, 3'd2, 1'b0);
        run("ret_201",  OP_RET,  1'b0, 8'h00, 10'd0,   10'd201, 3'd1, 1'b0);
        run("ret_11",   OP_RET,  1'b0, 8'h00, 10'd0,   10'd11,  3'd0, 1'b0);

        // CALL immediately followed by RET
        run("call_700", OP_CALL, 1'b0, 8'h00, 10'd700, 10'd700, 3'd1, 1'b0);
        run("ret_12",   OP_RET,  1'b0, 8'h00, 10'd0,   10'd12,  3'd0, 1'b0);

        // Fill and overflow
        run("fill_1",    OP_CALL, 1'b0, 8'h00, 10'd1,   10'd1, 3'd1, 1'b0);
        run("fill_2",    OP_CALL, 1'b0, 8'h00, 10'd2,   10'd2, 3'd2, 1'b0);
        run("fill_3",    OP_CALL, 1'b0, 8'h00, 10'd3,   10'd3, 3'd3, 1'b0);
        run("fill_4",    OP_CALL, 1'b0, 8'h00, 10'd4,   10'd4, 3'd4, 1'b0);
        run("overflow",  OP_CALL, 1'b0, 8'h00, 10'd900, 10'd4, 3'd4, 1'b1);
        run("next_flt",  OP_NEXT, 1'b0, 8'h00, 10'd0,   10'd5, 3'd4, 1'b1);
        run("ret_after", OP_RET,  1'b0, 8'h00, 10'd0,   10'd4, 3'd3, 1'b1);

        // Disabled CALL and reserved ops hold state
        step("disabled_call", 1'b1, 1'b0, OP_CALL, 1'b0, 8'h00, 10'd77, 10'd4, 3'd3, 1'b1);
        run("reserved_6",     3'd6,   1'b1, 8'h05, 10'd77, 10'd4, 3'd3, 1'b1);
        run("reserved_7",     3'd7,   1'b1, 8'h05, 10'd77, 10'd4, 3'd3, 1'b1);

        // Underflow after reset
        step("reset_clr", 1'b0, 1'b1, OP_RET, 1'b0, 8'h00, 10'd0, 10'd0, 3'd0, 1'b0);
        run("underflow",  OP_RET,  1'b0, 8'h00, 10'd0, 10'd0, 3'd0, 1'b1);
        run("next_uflt",  OP_NEXT, 1'b0, 8'h00, 10'd0, 10'd1, 3'd0, 1'b1);

        // Reset with CALL pending at depth 2
        step("reset_again", 1'b0, 1'b0, OP_NEXT, 1'b0, 8'h00, 10'd0, 10'd0, 3'd0, 1'b0);
        run("jump_20",   OP_JUMP, 1'b0, 8'h00, 10'd20, 10'd20, 3'd0, 1'b0);
        run("call_30",   OP_CALL, 1'b0, 8'h00, 10'd30, 10'd30, 3'd1, 1'b0);
        run("call_40",   OP_CALL, 1'b0, 8'h00, 10'd40, 10'd40, 3'd2, 1'b0);
        step("reset_call_d2", 1'b0, 1'b1, OP_CALL, 1'b0, 8'h00, 10'd50, 10'd0, 3'd0, 1'b0);
        run("ret_empty", OP_RET,  1'b0, 8'h00, 10'd0,  10'd0,  3'd0, 1'b1);

        // Pushed return address wraps
        run("jump_top",  OP_JUMP, 1'b0, 8'h00, 10'd1023, 10'd1023, 3'd0, 1'b1);
        run("call_wrap", OP_CALL, 1'b0, 8'h00, 10'd8,    10'd8,    3'd1, 1'b1);
        run("ret_wrap",  OP_RET,  1'b0, 8'h00, 10'd0,    10'd0,    3'd0, 1'b1);

        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations unchecked, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
